// File: rtl/cola_eventos.sv
// cola_eventos: event queue between the button/sensor front end and the pet FSM.
// Each of the five toggle-level inputs is synchronised, and every level change
// becomes one event. Events wait in per-source sticky pending flags, then move
// one per cycle, in fixed priority order, into a small FIFO drained by the consumer.
// Optional feature: define EVT_DROP_CNT_EN to build the saturating counter of
// dropped events behind evt_drop_cnt. Without it the output is tied to zero.

module cola_eventos #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Senal_test_activado,
  input  logic       Senal_Energia,
  input  logic       Senal_Medicina,
  input  logic       Senal_fot,
  input  logic       Senal_ultrasonido,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  output logic       modo_test,
  output logic [7:0] evt_drop_cnt
);

  // Pointer width. DEPTH is a power of two, so the pointers wrap on their own.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The occupancy counter needs one more bit than the pointers so it can hold DEPTH.
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Source bit order is also the priority order. Bit 0 has the highest priority.
  // Bit i carries event code i+1.
  logic [4:0] rawIn;
  assign rawIn = {Senal_ultrasonido, Senal_fot, Senal_Medicina,
                  Senal_Energia, Senal_test_activado};

  logic [4:0]    sync1_q;
  logic [4:0]    sync2_q;
  logic [4:0]    hist_q;
  logic [1:0]    blank_q;
  logic [4:0]    pend_q;
  logic [4:0]    pend_d;
  logic [4:0]    evtDet;
  logic [4:0]    clrSel;
  logic [2:0]    pushCode;
  logic          push;
  logic          pop;
  logic          canWrite;
  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [CW-1:0] count_q;

  // Two-flop synchroniser plus history flop. Blank counter holds off edge detection after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
      blank_q <= 2'd3;
    end else begin
      sync1_q <= rawIn;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      if (blank_q != 2'd0) begin
        blank_q <= blank_q - 2'd1;
      end
    end
  end

  // History reloads during blanking, but edges are masked. A level already high
  // when reset is released therefore looks settled and does not create an event.
  assign evtDet = (blank_q == 2'd0) ? (sync2_q ^ hist_q) : 5'd0;

  assign pop      = (count_q != '0) && evt_ready;
  assign canWrite = (count_q != FULL_COUNT) || pop;

  // Pick the highest-priority pending source. It is written only if the FIFO has room this cycle.
  always_comb begin
    clrSel   = '0;
    pushCode = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pend_q[i]) begin
        clrSel    = '0;
        clrSel[i] = 1'b1;
        pushCode  = 3'(i + 1);
      end
    end
    if (!canWrite) begin
      clrSel   = '0;
      pushCode = 3'd0;
    end
  end

  assign push = |clrSel;

  // A source written this cycle gives up its flag. A fresh edge on it re-arms the flag.
  assign pend_d = (pend_q & ~clrSel) | evtDet;

  // Sticky pending flags, one per source.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // FIFO pointers and occupancy. A push and pop in the same cycle leaves the count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage. Slots are not reset, because an empty FIFO masks evt_code to zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= pushCode;
    end
  end

  assign evt_valid = (count_q != '0);
  assign evt_code  = evt_valid ? mem_q[rdPtr_q] : 3'd0;
  assign modo_test = sync2_q[0];

`ifdef EVT_DROP_CNT_EN
  logic [4:0] dropEvt;
  logic [2:0] dropCount;
  logic [8:0] dropSum;
  logic [7:0] dropCnt_q;
  logic [7:0] dropCnt_d;

  // An edge on a source whose flag is still set, and not written this cycle, is lost.
  assign dropEvt = evtDet & pend_q & ~clrSel;

  // Add this cycle's losses to the running total, saturating at 255.
  always_comb begin
    dropCount = 3'd0;
    for (int i = 0; i < 5; i++) begin
      dropCount = dropCount + {2'b00, dropEvt[i]};
    end
    dropSum   = {1'b0, dropCnt_q} + {6'd0, dropCount};
    dropCnt_d = dropSum[8] ? 8'hFF : dropSum[7:0];
  end

  // Dropped-event counter, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dropCnt_q <= 8'd0;
    end else begin
      dropCnt_q <= dropCnt_d;
    end
  end

  assign evt_drop_cnt = dropCnt_q;
`else
  assign evt_drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_cola_eventos.sv
// Testbench for cola_eventos: directed scenarios plus a randomized run,
// all checked against a queue-based behavioural model of the event queue.
`timescale 1ns/1ps

module tb_cola_eventos;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       Senal_test_activado = 1'b0;
  logic       Senal_Energia = 1'b0;
  logic       Senal_Medicina = 1'b0;
  logic       Senal_fot = 1'b0;
  logic       Senal_ultrasonido = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic       modo_test;
  logic [7:0] evt_drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cola_eventos #(.DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .reset               (reset),
    .Senal_test_activado (Senal_test_activado),
    .Senal_Energia       (Senal_Energia),
    .Senal_Medicina      (Senal_Medicina),
    .Senal_fot           (Senal_fot),
    .Senal_ultrasonido   (Senal_ultrasonido),
    .evt_ready           (evt_ready),
    .evt_valid           (evt_valid),
    .evt_code            (evt_code),
    .modo_test           (modo_test),
    .evt_drop_cnt        (evt_drop_cnt)
  );

  // The reference model keeps a short queue of sampled input words, a per-source
  // pending flag, the FIFO as a queue of codes, and a drop tally.
  // A change becomes visible two samples after it is taken.
  // Edges are ignored for the first three clocks after reset.
  logic [4:0] mSamp [$];
  logic [4:0] mPend;
  logic [4:0] mEv;
  int         mFifo [$];
  int         mEdges;
  int         mDrops;
  int         mSel;
  bit         mPop;

  // Advance the model once per rising edge. Clear it whenever reset is low.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mSamp  = {5'd0, 5'd0, 5'd0};
      mPend  = 5'd0;
      mFifo.delete();
      mEdges = 0;
      mDrops = 0;
    end else begin
      mEv  = (mEdges < 3) ? 5'd0 : (mSamp[1] ^ mSamp[0]);
      mPop = (mFifo.size() > 0) && evt_ready;
      mSel = -1;
      for (int i = 0; i < 5; i++) begin
        if (mSel < 0 && mPend[i] && (mFifo.size() < DEPTH || mPop)) begin
          mSel = i;
        end
      end
      if (mPop) begin
        void'(mFifo.pop_front());
      end
      if (mSel >= 0) begin
        mFifo.push_back(mSel + 1);
        mPend[mSel] = 1'b0;
      end
      for (int i = 0; i < 5; i++) begin
        if (mEv[i]) begin
          if (mPend[i]) begin
            if (mDrops < 255) mDrops++;
          end else begin
            mPend[i] = 1'b1;
          end
        end
      end
      void'(mSamp.pop_front());
      mSamp.push_back({Senal_ultrasonido, Senal_fot, Senal_Medicina,
                       Senal_Energia, Senal_test_activado});
      mEdges++;
    end
  end

  function automatic int expDrop();
`ifdef EVT_DROP_CNT_EN
    return mDrops;
`else
    return 0;
`endif
  endfunction

  // Reset values, then release with Senal_Energia already high: no event may appear.
  task automatic test_reset();
    reset = 1'b0;
    Senal_Energia = 1'b1;
    evt_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", evt_valid); end
    checks++; if (evt_code !== 3'd0) begin errors++; $display("[TB] FAIL reset_code: got %0d expected 0", evt_code); end
    checks++; if (modo_test !== 1'b0) begin errors++; $display("[TB] FAIL reset_modo: got %0b expected 0", modo_test); end
    checks++; if (evt_drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_drop: got %0d expected 0", evt_drop_cnt); end
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL held_level_no_event cycle %0d: got %0b expected 0", c, evt_valid); end
    end
  endtask

  // A single Medicina change must show up on the fourth edge, and one pop must empty the FIFO.
  task automatic test_single_latency();
    evt_ready = 1'b0;
    @(negedge clk);
    Senal_Medicina = ~Senal_Medicina;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      if (e < 4) begin
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_early edge %0d: got %0b expected 0", e, evt_valid); end
      end else begin
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("[TB] FAIL latency_valid: got %0b expected 1", evt_valid); end
        checks++; if (evt_code !== 3'd3) begin errors++; $display("[TB] FAIL latency_code: got %0d expected 3", evt_code); end
      end
    end
    evt_ready = 1'b1;
    @(negedge clk);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_pop: got %0b expected 0", evt_valid); end
    evt_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Changes on fot and test in the same cycle are delivered by priority, on consecutive cycles.
  task automatic test_back_to_back();
    evt_ready = 1'b1;
    @(negedge clk);
    Senal_fot = ~Senal_fot;
    Senal_test_activado = ~Senal_test_activado;
    repeat (3) @(negedge clk);
    @(negedge clk);
    checks++; if (evt_valid !== 1'b1 || evt_code !== 3'd1) begin errors++; $display("[TB] FAIL b2b_first: got valid %0b code %0d expected 1/1", evt_valid, evt_code); end
    checks++; if (modo_test !== Senal_test_activado) begin errors++; $display("[TB] FAIL b2b_modo: got %0b expected %0b", modo_test, Senal_test_activado); end
    @(negedge clk);
    checks++; if (evt_valid !== 1'b1 || evt_code !== 3'd4) begin errors++; $display("[TB] FAIL b2b_second: got valid %0b code %0d expected 1/4", evt_valid, evt_code); end
    @(negedge clk);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_empty: got %0b expected 0", evt_valid); end
    evt_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Five sources change at once: four fill the FIFO, and the fifth waits until a pop makes room.
  task automatic test_fill_pending();
    int expA [4] = '{2, 3, 4, 5};
    evt_ready = 1'b0;
    @(negedge clk);
    Senal_test_activado = ~Senal_test_activado;
    Senal_Energia = ~Senal_Energia;
    Senal_Medicina = ~Senal_Medicina;
    Senal_fot = ~Senal_fot;
    Senal_ultrasonido = ~Senal_ultrasonido;
    repeat (10) @(negedge clk);
    checks++; if (evt_valid !== 1'b1 || evt_code !== 3'd1) begin errors++; $display("[TB] FAIL fill_head: got valid %0b code %0d expected 1/1", evt_valid, evt_code); end
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    checks++; if (evt_code !== 3'd2) begin errors++; $display("[TB] FAIL fill_after_pop: got %0d expected 2", evt_code); end
    repeat (3) @(negedge clk);
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (evt_valid !== 1'b1 || evt_code !== 3'(expA[i])) begin errors++; $display("[TB] FAIL fill_drain[%0d]: got valid %0b code %0d expected 1/%0d", i, evt_valid, evt_code, expA[i]); end
      @(negedge clk);
    end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL fill_empty: got %0b expected 0", evt_valid); end
    checks++; if (evt_drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL fill_drop: got %0d expected 0", evt_drop_cnt); end
    evt_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // With the FIFO full, three Energia changes give one pending event and two dropped ones.
  task automatic test_drops();
    int expA [5] = '{1, 3, 4, 5, 2};
    int expD;
`ifdef EVT_DROP_CNT_EN
    expD = 2;
`else
    expD = 0;
`endif
    evt_ready = 1'b0;
    @(negedge clk);
    Senal_test_activado = ~Senal_test_activado;
    Senal_Medicina = ~Senal_Medicina;
    Senal_fot = ~Senal_fot;
    Senal_ultrasonido = ~Senal_ultrasonido;
    repeat (10) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      Senal_Energia = ~Senal_Energia;
      repeat (10) @(negedge clk);
    end
    checks++; if (evt_drop_cnt !== 8'(expD)) begin errors++; $display("[TB] FAIL drop_count: got %0d expected %0d", evt_drop_cnt, expD); end
    checks++; if (evt_drop_cnt !== 8'(expDrop())) begin errors++; $display("[TB] FAIL drop_model: got %0d expected %0d", evt_drop_cnt, expDrop()); end
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (evt_valid !== 1'b1 || evt_code !== 3'(expA[i])) begin errors++; $display("[TB] FAIL drop_drain[%0d]: got valid %0b code %0d expected 1/%0d", i, evt_valid, evt_code, expA[i]); end
      @(negedge clk);
    end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL drop_empty: got %0b expected 0", evt_valid); end
    evt_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Random input changes and random back-pressure, compared with the model every cycle.
  task automatic test_random();
    int expC;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      expC = (mFifo.size() > 0) ? mFifo[0] : 0;
      checks++; if (evt_valid !== (mFifo.size() > 0)) begin errors++; $display("[TB] FAIL rand_valid cycle %0d: got %0b expected %0b", c, evt_valid, mFifo.size() > 0); end
      checks++; if (evt_code !== 3'(expC)) begin errors++; $display("[TB] FAIL rand_code cycle %0d: got %0d expected %0d", c, evt_code, expC); end
      checks++; if (modo_test !== mSamp[1][0]) begin errors++; $display("[TB] FAIL rand_modo cycle %0d: got %0b expected %0b", c, modo_test, mSamp[1][0]); end
      checks++; if (evt_drop_cnt !== 8'(expDrop())) begin errors++; $display("[TB] FAIL rand_drop cycle %0d: got %0d expected %0d", c, evt_drop_cnt, expDrop()); end
      if ($urandom_range(0, 7) == 0) Senal_test_activado = ~Senal_test_activado;
      if ($urandom_range(0, 7) == 0) Senal_Energia = ~Senal_Energia;
      if ($urandom_range(0, 7) == 0) Senal_Medicina = ~Senal_Medicina;
      if ($urandom_range(0, 7) == 0) Senal_fot = ~Senal_fot;
      if ($urandom_range(0, 7) == 0) Senal_ultrasonido = ~Senal_ultrasonido;
      evt_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Reset asserted while three entries are queued clears everything at once. No stale code may follow.
  task automatic test_reset_mid();
    evt_ready = 1'b1;
    repeat (20) @(negedge clk);
    evt_ready = 1'b0;
    Senal_Energia = ~Senal_Energia;
    Senal_Medicina = ~Senal_Medicina;
    Senal_fot = ~Senal_fot;
    repeat (10) @(negedge clk);
    checks++; if (evt_valid !== 1'b1 || evt_code !== 3'd2) begin errors++; $display("[TB] FAIL mid_queued: got valid %0b code %0d expected 1/2", evt_valid, evt_code); end
    #2 reset = 1'b0;
    #1;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_valid: got %0b expected 0", evt_valid); end
    checks++; if (evt_code !== 3'd0) begin errors++; $display("[TB] FAIL mid_async_code: got %0d expected 0", evt_code); end
    checks++; if (evt_drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL mid_async_drop: got %0d expected 0", evt_drop_cnt); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    evt_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if (evt_valid !== 1'b0 || evt_code !== 3'd0) begin errors++; $display("[TB] FAIL mid_after cycle %0d: got valid %0b code %0d expected 0/0", c, evt_valid, evt_code); end
    end
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_back_to_back();
    test_fill_pending();
    test_drops();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
